// File: rtl/vga_frame_reader.sv
// Streams one H_RES x V_RES frame from word-addressed memory into a pixel FIFO.
// Define VGA_FRAME_READER_ERR_EN to build the sticky FIFO overflow flag on err.
module vga_frame_reader #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int AWIDTH  = 19,
    parameter int DWIDTH  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [DWIDTH-1:0] fifo_din,
    output logic              fifo_write,
    input  logic              fifo_afull,
    input  logic              fifo_full,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | issuing read requests for the frame
    // DRAIN | all requests issued, waiting for data and the last FIFO write
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int                TOTAL     = H_RES * V_RES;
    localparam int                CWIDTH    = $clog2(TOTAL + 1);
    localparam logic [CWIDTH-1:0] LAST_REQ  = CWIDTH'(TOTAL - 1);
    localparam logic [3:0]        OUT_LIMIT = 4'(MAX_OUT);

    logic [1:0]        state;
    logic [AWIDTH-1:0] addr_q;
    logic [CWIDTH-1:0] req_cnt;
    logic [3:0]        out_cnt;
    logic              req_hold;
    logic              wr_q;
    logic [DWIDTH-1:0] din_q;
    logic              done_q;
    logic              accept;
    logic              rsp_take;

    // A request left unaccepted stays up regardless of afull or the outstanding limit.
    assign mem_req  = (state == FETCH) && (req_hold || (!fifo_afull && (out_cnt < OUT_LIMIT)));
    assign accept   = mem_req && mem_ready;
    assign rsp_take = mem_rvalid && (out_cnt != 4'd0);

    assign mem_addr   = addr_q;
    assign busy       = (state != IDLE);
    assign frame_done = done_q;
    assign fifo_write = wr_q;
    assign fifo_din   = din_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            req_cnt  <= '0;
            out_cnt  <= '0;
            req_hold <= 1'b0;
            wr_q     <= 1'b0;
            din_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wr_q     <= rsp_take;
            req_hold <= mem_req && !mem_ready;
            if (rsp_take) begin
                din_q <= mem_rdata;
            end
            if (accept && !rsp_take) begin
                out_cnt <= out_cnt + 4'd1;
            end else if (!accept && rsp_take) begin
                out_cnt <= out_cnt - 4'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        req_cnt <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        addr_q  <= addr_q + AWIDTH'(1);
                        req_cnt <= req_cnt + CWIDTH'(1);
                        if (req_cnt == LAST_REQ) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the final pixel's registered write has gone out.
                    if ((out_cnt == 4'd0) && !wr_q) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VGA_FRAME_READER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (wr_q && fifo_full) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_fifo_full;

    assign unused_fifo_full = fifo_full;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized bench for vga_frame_reader: a memory model with variable latency and
// ready, plus an expected address stream and expected pixel queue.
module tb_vga_frame_reader;
    localparam int H_RES   = 4;
    localparam int V_RES   = 2;
    localparam int AWIDTH  = 19;
    localparam int DWIDTH  = 16;
    localparam int MAX_OUT = 2;
    localparam int NPIX    = H_RES * V_RES;
`ifdef VGA_FRAME_READER_ERR_EN
    localparam logic [31:0] ERR_EN = 32'd1;
`else
    localparam logic [31:0] ERR_EN = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AWIDTH-1:0] base_addr = '0;
    logic              busy;
    logic              frame_done;
    logic              mem_req;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_ready = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DWIDTH-1:0] mem_rdata = '0;
    logic [DWIDTH-1:0] fifo_din;
    logic              fifo_write;
    logic              fifo_afull = 1'b0;
    logic              fifo_full = 1'b0;
    logic              err;

    vga_frame_reader #(
        .H_RES(H_RES), .V_RES(V_RES), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .frame_done(frame_done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fifo_din(fifo_din), .fifo_write(fifo_write), .fifo_afull(fifo_afull),
        .fifo_full(fifo_full), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        int                due;
        logic [DWIDTH-1:0] data;
    } rsp_t;

    rsp_t              rsp_q[$];
    logic [DWIDTH-1:0] exp_fifo[$];
    logic [AWIDTH-1:0] exp_addr = '0;
    logic [DWIDTH-1:0] salt = '0;
    int  cyc = 0, lat = 1, ready_pct = 100, last_due = 0;
    int  tb_out = 0, peak_out = 0, n_acc = 0, n_wr = 0, n_done = 0, n_unexp = 0;
    int  hold_viol = 0, afull_viol = 0, limit_viol = 0;
    bit  afull_force = 1'b0;
    bit  prev_pending = 1'b0;
    bit  s_req = 1'b0;
    logic [AWIDTH-1:0] prev_addr = '0;

    function automatic logic [DWIDTH-1:0] mem_word(input logic [AWIDTH-1:0] a);
        return DWIDTH'(a * 5) ^ salt;
    endfunction

    // One clock: drive inputs after the falling edge, sample 1 ns later, update the model.
    task automatic cycle();
        bit took;
        int d;
        @(negedge clk);
        cyc++;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        mem_ready  = ($urandom_range(99) < ready_pct);
        fifo_afull = afull_force;
        #1;
        s_req = mem_req;
        if (frame_done === 1'b1) n_done++;
        if (fifo_write === 1'b1) begin
            n_wr++;
            if (exp_fifo.size() == 0) n_unexp++;
            else check("fifo_din", 32'(fifo_din), 32'(exp_fifo.pop_front()));
        end
        if (rst_n) begin
            if (prev_pending && (!mem_req || mem_addr !== prev_addr)) hold_viol++;
            if (mem_req && !prev_pending && fifo_afull) afull_viol++;
            if (mem_req && !prev_pending && tb_out >= MAX_OUT) limit_viol++;
            took = mem_req && mem_ready;
            if (took) begin
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr = exp_addr + 1'b1;
                n_acc++;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                rsp_q.push_back('{d, mem_word(mem_addr)});
            end
            if (mem_rvalid && tb_out > 0) begin
                exp_fifo.push_back(mem_rdata);
                tb_out--;
            end
            if (took) tb_out++;
            if (tb_out > peak_out) peak_out = tb_out;
            prev_pending = mem_req && !mem_ready;
            prev_addr    = mem_addr;
        end else begin
            tb_out       = 0;
            prev_pending = 1'b0;
            exp_fifo.delete();
        end
    endtask

    task automatic run_frame(input logic [AWIDTH-1:0] base, input int l, input int rp,
                             input int af_after, input int rl_after, input string tag);
        int  budget, af_left, rl_left, rl_req;
        bit  af_used, rl_used;
        lat = l; ready_pct = rp; salt = DWIDTH'($urandom);
        n_wr = 0; n_done = 0; n_acc = 0; peak_out = 0;
        af_left = 0; rl_left = 0; rl_req = 0; af_used = 0; rl_used = 0;
        exp_addr  = base;
        base_addr = base;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        base_addr = AWIDTH'($urandom);
        cycle();
        check({tag, "_busy_on"}, 32'(busy), 1);
        budget = 0;
        while (n_done == 0 && budget < 500) begin
            if (!af_used && af_after >= 0 && n_acc >= af_after) begin
                af_used = 1; af_left = 10;
            end
            if (!rl_used && rl_after >= 0 && n_acc >= rl_after) begin
                rl_used = 1; rl_left = 3;
            end
            afull_force = (af_left > 0);
            ready_pct   = (rl_left > 0) ? 0 : rp;
            cycle();
            if (rl_left > 0 && s_req) rl_req++;
            if (af_left > 0) af_left--;
            if (rl_left > 0) rl_left--;
            budget++;
        end
        afull_force = 1'b0;
        ready_pct   = rp;
        check({tag, "_no_timeout"}, 32'(n_done != 0), 1);
        cycle();
        cycle();
        check({tag, "_done_cnt"}, 32'(n_done), 1);
        check({tag, "_acc_cnt"}, 32'(n_acc), NPIX);
        check({tag, "_wr_cnt"}, 32'(n_wr), NPIX);
        check({tag, "_busy_off"}, 32'(busy), 0);
        if (rl_after >= 0) check({tag, "_ready_low_req"}, 32'(rl_req), 3);
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        repeat (3) cycle();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_fifo_write", 32'(fifo_write), 0);
        check("rst_fifo_din", 32'(fifo_din), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        cycle();

        run_frame(19'h100, 1, 100, -1, -1, "basic");
        run_frame(19'h2a0, 5, 100, -1, -1, "lat5");
        check("lat5_peak_out", 32'(peak_out), MAX_OUT);
        run_frame(19'h7fffd, 2, 70, -1, -1, "wrap");
        run_frame(19'h040, 3, 50, 2, -1, "afull");
        run_frame(19'h300, 1, 100, -1, 2, "ready_low");
        for (int i = 0; i < 5; i++) begin
            run_frame(AWIDTH'($urandom), $urandom_range(6, 1), $urandom_range(100, 30),
                      -1, -1, "rand");
        end

        // Abort mid-frame: late responses must be dropped.
        lat = 6; ready_pct = 100; n_acc = 0;
        exp_addr = 19'h500; base_addr = 19'h500; start = 1'b1;
        cycle();
        start = 1'b0;
        budget = 0;
        while (n_acc < 3 && budget < 100) begin
            cycle();
            budget++;
        end
        check("abort_three_acc", 32'(n_acc), 3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_wr = 0; n_done = 0;
        repeat (12) cycle();
        check("abort_wr_cnt", 32'(n_wr), 0);
        check("abort_done_cnt", 32'(n_done), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_mem_req", 32'(mem_req), 0);
        check("abort_mem_addr", 32'(mem_addr), 0);
        check("abort_fifo_din", 32'(fifo_din), 0);
        check("abort_err", 32'(err), 0);

        // Overflow flag.
        fifo_full = 1'b1;
        run_frame(19'h600, 1, 100, -1, -1, "full");
        fifo_full = 1'b0;
        check("err_set", 32'(err), ERR_EN);
        repeat (5) cycle();
        check("err_sticky", 32'(err), ERR_EN);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("err_cleared", 32'(err), 0);

        check("hold_viol", 32'(hold_viol), 0);
        check("afull_viol", 32'(afull_viol), 0);
        check("limit_viol", 32'(limit_viol), 0);
        check("unexpected_writes", 32'(n_unexp), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
